// File: rtl/dyn_phase_ctrl_if.sv
// dyn_phase_ctrl_if: shift-request handshake between requester and phase controller
interface dyn_phase_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [3:0] REQ_COUNTER;
  logic       REQ_UPDN;
  logic [7:0] REQ_STEPS;
  modport master(output REQ_VALID, REQ_COUNTER, REQ_UPDN, REQ_STEPS, input REQ_READY);
  modport slave(input REQ_VALID, REQ_COUNTER, REQ_UPDN, REQ_STEPS, output REQ_READY);
endinterface

// File: rtl/dyn_phase_ctrl.sv
// dyn_phase_ctrl: sequences PLL dynamic phase steps (PHASESTEP pulse, PHASEDONE low/high handshake)
module dyn_phase_ctrl #(
  parameter int P_STEP_HIGH = 2,
  parameter int P_TIMEOUT   = 255
) (
  input  logic                   CLK50M,
  input  logic                   RESET,
  dyn_phase_ctrl_if.slave        req,
  input  logic                   ABORT,
  output logic [3:0]             PLL_PHASECOUNTERSELECT,
  output logic                   PLL_PHASEUPDOWN,
  output logic                   PLL_PHASESTEP,
  input  logic                   PLL_PHASEDONE,
  output logic                   BUSY,
  output logic                   DONE_PLS,
  output logic                   TIMEOUT_ERR,
  output logic [7:0]             STEP_CNT
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STEP    = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;
  localparam logic [3:0]  HI_LAST = 4'(P_STEP_HIGH - 1);
  localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [1:0]  pd_q;
  logic        pd_s;
  logic [3:0]  sel_q;
  logic        updn_q;
  logic [7:0]  steps_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  hi_q, hi_d;
  logic [15:0] tlo_q, tlo_d;
  logic [15:0] thi_q, thi_d;
  logic        abort_q, abort_d;
  logic        err_q, err_d;
  logic        accept;
  assign pd_s                   = pd_q[1];
  assign accept                 = req.REQ_VALID && state_q == IDLE;
  assign req.REQ_READY          = state_q == IDLE;
  assign BUSY                   = state_q != IDLE;
  assign DONE_PLS               = state_q == DONE;
  assign PLL_PHASESTEP          = state_q == STEP;
  assign PLL_PHASECOUNTERSELECT = sel_q;
  assign PLL_PHASEUPDOWN        = updn_q;
  assign TIMEOUT_ERR            = err_q;
  assign STEP_CNT               = cnt_q;
  // Timeout counters default to zero so each wait state starts counting fresh on entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hi_d    = '0;
    tlo_d   = '0;
    thi_d   = '0;
    abort_d = state_q == IDLE ? 1'b0 : abort_q | ABORT;
    case (state_q)
      IDLE: if (accept) begin
        state_d = req.REQ_STEPS == 8'd0 ? DONE : SETUP;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      SETUP: state_d = STEP;
      STEP: begin
        hi_d    = hi_q == HI_LAST ? 4'd0 : hi_q + 4'd1;
        state_d = hi_q == HI_LAST ? WAIT_LO : STEP;
      end
      WAIT_LO: if (!pd_s) state_d = WAIT_HI;
        else if (tlo_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else tlo_d = tlo_q + 16'd1;
      WAIT_HI: if (pd_s) state_d = NEXT;
        else if (thi_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else thi_d = thi_q + 16'd1;
      NEXT: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_d == steps_q || abort_q) ? DONE : STEP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      state_q <= IDLE;
      pd_q    <= 2'b11;
      sel_q   <= '0;
      updn_q  <= 1'b0;
      steps_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      tlo_q   <= '0;
      thi_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pd_q    <= {pd_q[0], PLL_PHASEDONE};
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      tlo_q   <= tlo_d;
      thi_q   <= thi_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      if (accept) begin
        sel_q   <= req.REQ_COUNTER;
        updn_q  <= req.REQ_UPDN;
        steps_q <= req.REQ_STEPS;
      end
    end
  end
endmodule

// File: tb/tb_dyn_phase_ctrl.sv
// tb_dyn_phase_ctrl: directed checks of the phase-step sequencer against a small PLL model
module tb_dyn_phase_ctrl;
  logic       CLK50M = 1'b0;
  logic       RESET  = 1'b1;
  logic       ABORT  = 1'b0;
  logic [3:0] PLL_PHASECOUNTERSELECT;
  logic       PLL_PHASEUPDOWN, PLL_PHASESTEP, PLL_PHASEDONE;
  logic       BUSY, DONE_PLS, TIMEOUT_ERR;
  logic [7:0] STEP_CNT;
  dyn_phase_ctrl_if bus();
  dyn_phase_ctrl #(.P_STEP_HIGH(2), .P_TIMEOUT(20)) dut (
    .CLK50M(CLK50M),
    .RESET(RESET),
    .req(bus),
    .ABORT(ABORT),
    .PLL_PHASECOUNTERSELECT(PLL_PHASECOUNTERSELECT),
    .PLL_PHASEUPDOWN(PLL_PHASEUPDOWN),
    .PLL_PHASESTEP(PLL_PHASESTEP),
    .PLL_PHASEDONE(PLL_PHASEDONE),
    .BUSY(BUSY),
    .DONE_PLS(DONE_PLS),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .STEP_CNT(STEP_CNT)
  );
  always #10 CLK50M = ~CLK50M;
  // PLL model: PHASEDONE drops 2 cycles after PHASESTEP rises, for 4 cycles
  int   pd_age = 0;
  logic st_prev_pll = 1'b0;
  logic pd_force = 1'b0;
  always @(posedge CLK50M) begin
    st_prev_pll <= PLL_PHASESTEP;
    pd_age <= (PLL_PHASESTEP && !st_prev_pll) ? 1 : (pd_age > 0 && pd_age < 6) ? pd_age + 1 : 0;
  end
  assign PLL_PHASEDONE = pd_force || !(pd_age >= 2 && pd_age <= 5);
  int   cyc = 0, n_pulse = 0, n_done = 0, n_setup = 0, bad_hi = 0, bad_sel = 0, hi_run = 0;
  int   rise_cyc = -1, done_cyc = -1, err_cyc = -1, ready_cyc = -1;
  logic st_prev = 1'b0, err_prev = 1'b0, rdy_prev = 1'b1;
  logic [3:0] exp_sel = '0;
  logic       exp_updn = 1'b0;
  always @(negedge CLK50M) begin
    cyc++;
    if (PLL_PHASESTEP) hi_run++;
    else begin
      if (hi_run != 0 && hi_run != 2) bad_hi++;
      hi_run = 0;
    end
    if (PLL_PHASESTEP && !st_prev) begin n_pulse++; rise_cyc = cyc; end
    if (DONE_PLS) begin n_done++; done_cyc = cyc; end
    if (TIMEOUT_ERR && !err_prev) err_cyc = cyc;
    if (bus.REQ_READY && !rdy_prev) ready_cyc = cyc;
    if (int'(dut.state_q) == 1) n_setup++;
    if (BUSY && !RESET && (PLL_PHASECOUNTERSELECT != exp_sel || PLL_PHASEUPDOWN != exp_updn)) bad_sel++;
    st_prev  = PLL_PHASESTEP;
    err_prev = TIMEOUT_ERR;
    rdy_prev = bus.REQ_READY;
  end
  int n_chk = 0, n_bad = 0;
  int acc, b_pulse, b_done, b_setup, b_hi, b_sel;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic snap();
    b_pulse = n_pulse; b_done = n_done; b_setup = n_setup; b_hi = bad_hi; b_sel = bad_sel;
  endtask
  task automatic send(input logic [3:0] c, input logic u, input logic [7:0] s, input int hold);
    @(posedge CLK50M); #1;
    bus.REQ_COUNTER = c; bus.REQ_UPDN = u; bus.REQ_STEPS = s; bus.REQ_VALID = 1'b1;
    exp_sel = c; exp_updn = u; acc = cyc + 1;
    repeat (hold) @(posedge CLK50M);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_COUNTER = ~c; bus.REQ_UPDN = ~u; bus.REQ_STEPS = s + 8'd3;
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    do begin @(negedge CLK50M); k++; end while (!DONE_PLS && k < budget);
    if (!DONE_PLS) chk("done_wait", 0, 1);
    @(posedge CLK50M); #1;
  endtask
  task automatic wait_pulse(input int n);
    int k = 0;
    do begin @(negedge CLK50M); #1; k++; end while (n_pulse < n && k < 300);
    if (n_pulse < n) chk("pulse_wait", n_pulse, n);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    bus.REQ_VALID = 1'b0; bus.REQ_COUNTER = '0; bus.REQ_UPDN = 1'b0; bus.REQ_STEPS = '0;
    repeat (3) @(posedge CLK50M);
    #1;
    chk("rst_step", PLL_PHASESTEP, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cnt", STEP_CNT, 0);
    chk("rst_sel", {PLL_PHASEUPDOWN, PLL_PHASECOUNTERSELECT}, 0);
    RESET = 1'b0;
    @(negedge CLK50M);
    chk("rst_ready", bus.REQ_READY, 1);
    // single step, select=3 up
    snap();
    send(4'd3, 1'b1, 8'd1, 1);
    wait_done(100);
    chk("t1_rise", rise_cyc, acc + 2);
    chk("t1_pulses", n_pulse - b_pulse, 1);
    chk("t1_hi", bad_hi - b_hi, 0);
    chk("t1_sel", bad_sel - b_sel, 0);
    chk("t1_done_cyc", done_cyc, acc + 12);
    chk("t1_done_n", n_done - b_done, 1);
    chk("t1_cnt", STEP_CNT, 1);
    chk("t1_err", TIMEOUT_ERR, 0);
    // five steps, request fields scrambled after accept
    snap();
    send(4'd12, 1'b0, 8'd5, 1);
    wait_done(200);
    chk("t2_pulses", n_pulse - b_pulse, 5);
    chk("t2_setup", n_setup - b_setup, 1);
    chk("t2_hi", bad_hi - b_hi, 0);
    chk("t2_sel", bad_sel - b_sel, 0);
    chk("t2_done_cyc", done_cyc, acc + 52);
    chk("t2_done_n", n_done - b_done, 1);
    chk("t2_cnt", STEP_CNT, 5);
    // zero steps
    snap();
    send(4'd6, 1'b1, 8'd0, 1);
    repeat (4) @(posedge CLK50M);
    #1;
    chk("t3_done_cyc", done_cyc, acc + 1);
    chk("t3_ready", ready_cyc, acc + 2);
    chk("t3_pulses", n_pulse - b_pulse, 0);
    chk("t3_cnt", STEP_CNT, 0);
    // valid held through DONE is taken on the next IDLE cycle
    snap();
    send(4'd6, 1'b1, 8'd0, 3);
    repeat (4) @(posedge CLK50M);
    #1;
    chk("t3b_done_n", n_done - b_done, 2);
    chk("t3b_done_cyc", done_cyc, acc + 3);
    // PHASEDONE stuck high -> timeout in WAIT_LO
    pd_force = 1'b1;
    snap();
    send(4'd5, 1'b0, 8'd2, 1);
    wait_done(100);
    chk("t4_err_cyc", err_cyc, acc + 24);
    chk("t4_done_cyc", done_cyc, acc + 24);
    chk("t4_pulses", n_pulse - b_pulse, 1);
    chk("t4_cnt", STEP_CNT, 0);
    repeat (5) @(posedge CLK50M);
    #1;
    chk("t4_err_hold", TIMEOUT_ERR, 1);
    pd_force = 1'b0;
    repeat (4) @(posedge CLK50M);
    send(4'd1, 1'b1, 8'd0, 1);
    chk("t4_err_clr", TIMEOUT_ERR, 0);
    repeat (3) @(posedge CLK50M);
    // abort during the 3rd of 10 steps
    snap();
    send(4'd7, 1'b0, 8'd10, 1);
    wait_pulse(b_pulse + 3);
    @(posedge CLK50M); #1;
    ABORT = 1'b1;
    @(posedge CLK50M); #1;
    ABORT = 1'b0;
    wait_done(100);
    chk("t5_cnt", STEP_CNT, 3);
    chk("t5_hi", bad_hi - b_hi, 0);
    repeat (30) @(posedge CLK50M);
    #1;
    chk("t5_pulses", n_pulse - b_pulse, 3);
    chk("t5_done_n", n_done - b_done, 1);
    // reset while PHASESTEP is high in step 2 of 4
    snap();
    send(4'd9, 1'b1, 8'd4, 1);
    wait_pulse(b_pulse + 2);
    chk("t6_pre_step", PLL_PHASESTEP, 1);
    RESET = 1'b1;
    @(posedge CLK50M); #1;
    chk("t6_step", PLL_PHASESTEP, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_cnt", STEP_CNT, 0);
    chk("t6_sel", {PLL_PHASEUPDOWN, PLL_PHASECOUNTERSELECT}, 0);
    chk("t6_done", DONE_PLS, 0);
    @(posedge CLK50M); #1;
    RESET = 1'b0;
    chk("t6_ready", bus.REQ_READY, 1);
    repeat (15) @(posedge CLK50M);
    #1;
    chk("t6_no_done", n_done - b_done, 0);
    snap();
    send(4'd2, 1'b0, 8'd1, 1);
    wait_done(100);
    chk("t6_new_cnt", STEP_CNT, 1);
    chk("t6_new_sel", PLL_PHASECOUNTERSELECT, 2);
    chk("t6_new_pulses", n_pulse - b_pulse, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/dyn_phase_ctrl.md
DYN_PHASE_CTRL -- requirements
Module: dyn_phase_ctrl

Interface
REQ-001 The block SHALL have parameters:
- P_STEP_HIGH, default 2: PLL_PHASESTEP high time in cycles (legal 2..15).
- P_TIMEOUT, default 255: maximum cycles spent in each PHASEDONE wait state (legal 1..65535).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK50M  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  shift request valid.
- REQ_READY  out  1  high only in IDLE; a request is accepted on a cycle where REQ_VALID & REQ_READY.
- REQ_COUNTER  in  4  PLL counter select; captured at accept.
- REQ_UPDN  in  1  direction, 1=up, 0=down; captured at accept.
- REQ_STEPS  in  8  number of phase steps; captured at accept; 0 is legal.
- ABORT  in  1  stop after the step in progress.
- PLL_PHASECOUNTERSELECT  out  4  to PLL.
- PLL_PHASEUPDOWN  out  1  to PLL.
- PLL_PHASESTEP  out  1  to PLL.
- PLL_PHASEDONE  in  1  from PLL; asynchronous.
- BUSY  out  1  high in every state other than IDLE.
- DONE_PLS  out  1  one-cycle completion pulse.
- TIMEOUT_ERR  out  1  sticky error flag.
- STEP_CNT  out  8  steps completed for the current or last request.

Function
REQ-003 PLL_PHASEDONE SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value (pd_s).

REQ-004 The FSM states SHALL be IDLE, SETUP, STEP, WAIT_LO, WAIT_HI, NEXT and DONE, with the following transitions:
- IDLE->SETUP on accept when REQ_STEPS!=0.
- IDLE->DONE on accept when REQ_STEPS==0.

REQ-005 Accept SHALL latch counter, direction and step count, clear STEP_CNT to 0 and clear TIMEOUT_ERR.

REQ-006 SETUP SHALL last exactly 1 cycle, driving PLL_PHASECOUNTERSELECT/PLL_PHASEUPDOWN from the latched values; these outputs SHALL hold stable from SETUP until return to IDLE.

REQ-007 STEP SHALL drive PLL_PHASESTEP high for exactly P_STEP_HIGH cycles, then go to WAIT_LO; PLL_PHASESTEP SHALL be low in all other states.
- First PLL_PHASESTEP high cycle SHALL be 2 cycles after the accept cycle.

REQ-008 WAIT_LO SHALL wait for pd_s==0, then go to WAIT_HI; WAIT_HI SHALL wait for pd_s==1, then go to NEXT.

REQ-009 Each wait state SHALL own a 16-bit timeout counter:
- cleared on entry;
- when it reaches P_TIMEOUT without the awaited level, TIMEOUT_ERR SHALL set and the FSM SHALL go to DONE without incrementing STEP_CNT.

REQ-010 NEXT SHALL last 1 cycle and increment STEP_CNT, then:
- go to DONE if STEP_CNT+1 equals the latched step count, or if the abort flag is set;
- otherwise go to STEP. SETUP is not repeated.

REQ-011 ABORT SHALL be sampled while BUSY into an abort flag:
- It SHALL never truncate PLL_PHASESTEP or skip a wait state.
- It SHALL take effect only at NEXT or at the IDLE->DONE path.
- The abort flag SHALL clear on return to IDLE.

REQ-012 DONE SHALL last 1 cycle, assert DONE_PLS, then go to IDLE; REQ_READY SHALL be low in DONE.
- A REQ_VALID held through DONE SHALL be accepted on the following IDLE cycle.

REQ-013 STEP_CNT SHALL be 8-bit, never wrap (maximum 255 = REQ_STEPS maximum), and hold its value in IDLE until the next accept.

REQ-014 TIMEOUT_ERR SHALL remain set through IDLE until the next accept or reset.

REQ-015 REQ_COUNTER/REQ_UPDN/REQ_STEPS changes after accept SHALL have no effect on the request in progress.

REQ-016 pd_s already low on entry to WAIT_LO SHALL advance to WAIT_HI the next cycle; pd_s already high on entry to WAIT_HI SHALL advance to NEXT the next cycle.

Reset
REQ-017 RESET high at a rising edge SHALL force, at that edge:
- FSM = IDLE;
- PLL_PHASESTEP = 0, PLL_PHASECOUNTERSELECT = 4'b0000, PLL_PHASEUPDOWN = 0;
- BUSY = 0, DONE_PLS = 0, TIMEOUT_ERR = 0, STEP_CNT = 0;
- abort flag = 0, timeout counters = 0, synchronizer flops = 1;
- REQ_READY SHALL be 1 on the first cycle after RESET deasserts.

REQ-018 RESET asserted mid-operation, including while PLL_PHASESTEP is high, SHALL drop PLL_PHASESTEP at the next edge, leave no DONE_PLS, and discard the request.

Verification
REQ-019 Bench SHALL cover:
- COUNTER=3, UPDN=1, STEPS=1, PLL model drops PHASEDONE 2 cycles after PHASESTEP rise for 4 cycles -> PHASESTEP high exactly 2 cycles starting accept+2, select=3/updown=1 stable, one DONE_PLS, STEP_CNT=1, TIMEOUT_ERR=0.
- STEPS=5 with normal PLL model -> exactly 5 PHASESTEP pulses, SETUP seen once, STEP_CNT=5, single DONE_PLS.
- STEPS=0 -> no PHASESTEP, DONE_PLS at accept+1, STEP_CNT=0, REQ_READY back at accept+2.
- P_TIMEOUT=20, PLL holds PHASEDONE=1 -> TIMEOUT_ERR set 20 cycles after WAIT_LO entry, DONE_PLS, STEP_CNT=0, flag cleared by next accept.
- STEPS=10, ABORT pulsed during 3rd PHASESTEP -> 3rd step completes, STEP_CNT=3, DONE_PLS, no 4th PHASESTEP.
- RESET pulsed while PHASESTEP high in step 2 of 4 -> PHASESTEP low next edge, no DONE_PLS, all outputs at reset values, new request accepted normally.
